// File: rtl/fetch_pc_unit_pkg.sv
// Shared types for the fetch stage: PC/instruction widths, FSM encodings and the decode-facing record.
// Optional misaligned-target checking is enabled by FETCH_MISALIGN_CHECK_EN in fetch_pc_unit.sv.
package fetch_pc_unit_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  localparam u64 PCINIT = 64'h8000_0000;

  localparam logic [1:0] ST_REQ_ENC  = 2'd0;
  localparam logic [1:0] ST_DROP_ENC = 2'd1;
  localparam logic [1:0] ST_HOLD_ENC = 2'd2;
  localparam logic [1:0] ST_ERR_ENC  = 2'd3;

  typedef enum logic [1:0] {
    S_REQ  = ST_REQ_ENC,
    S_DROP = ST_DROP_ENC,
    S_HOLD = ST_HOLD_ENC,
    S_ERR  = ST_ERR_ENC
  } fetch_state_t;

  typedef struct packed {
    logic valid;
    u64   pc;
    u32   raw_instr;
    logic error;
  } fetch_data_t;

  function automatic u64 next_pc(input u64 pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched {pc, instr} while decode is stalled.
// Not affected by FETCH_MISALIGN_CHECK_EN.
module fetch_skid_buf
  import fetch_pc_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  logic [63:0] push_pc,
  input  logic [31:0] push_instr,
  output logic        full,
  output logic [63:0] pc,
  output logic [31:0] instr
);

  // clear wins so a redirect always discards a parked instruction
  always_ff @(posedge clk) begin
    if (!reset) begin
      full  <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (push) begin
      full  <= 1'b1;
      pc    <= push_pc;
      instr <= push_instr;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, drives the instruction bus, delivers f_* to decode.
// Define FETCH_MISALIGN_CHECK_EN to trap redirect targets with jump[1:0] != 0.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = PCINIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch,
  input  logic [63:0] jump,
  input  logic        stall,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_error
);

  fetch_state_t state;
  u64           pc;
  u64           old_addr;
  logic         err_pend;
  fetch_data_t  f_q;
  logic         misalign;

  logic         skid_push;
  logic         skid_pop;
  logic         skid_full;
  u64           skid_pc;
  u32           skid_instr;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign = |jump[1:0];
`else
  assign misalign = 1'b0;
`endif

  assign skid_push = (state == S_REQ) && iresp_data_ok && !branch && stall;
  assign skid_pop  = (state == S_HOLD) && skid_full && !branch && !stall;

  fetch_skid_buf u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (skid_push),
    .pop        (skid_pop),
    .clear      (branch),
    .push_pc    (pc),
    .push_instr (iresp_data),
    .full       (skid_full),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  // DROP keeps presenting the superseded address until its response retires
  assign ireq_valid = (state == S_REQ) || (state == S_DROP);
  assign ireq_addr  = (state == S_DROP) ? old_addr : pc;

  assign f_valid = f_q.valid;
  assign f_pc    = f_q.pc;
  assign f_instr = f_q.raw_instr;
  assign f_error = f_q.error;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      old_addr <= '0;
      err_pend <= 1'b0;
      f_q      <= '0;
    end else if (branch) begin
      f_q.valid <= 1'b0;
      f_q.error <= 1'b0;
      pc        <= jump;
      err_pend  <= misalign;
      case (state)
        S_REQ: begin
          if (!iresp_data_ok) begin
            state    <= S_DROP;
            old_addr <= pc;
          end else begin
            state <= misalign ? S_ERR : S_REQ;
          end
        end
        // a response retiring alongside a new redirect frees the bus immediately
        S_DROP:  if (iresp_data_ok) state <= misalign ? S_ERR : S_REQ;
        default: state <= misalign ? S_ERR : S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (iresp_data_ok) begin
            pc <= next_pc(pc);
            if (stall) state <= S_HOLD;
          end
        end
        S_DROP: if (iresp_data_ok) state <= err_pend ? S_ERR : S_REQ;
        S_HOLD: if (!stall) state <= S_REQ;
        S_ERR:  if (!stall) err_pend <= 1'b0;
        default: state <= S_REQ;
      endcase

      if (!stall) begin
        if ((state == S_REQ) && iresp_data_ok) begin
          f_q <= fetch_data_t'{valid: 1'b1, pc: pc, raw_instr: iresp_data, error: 1'b0};
        end else if ((state == S_HOLD) && skid_full) begin
          f_q <= fetch_data_t'{valid: 1'b1, pc: skid_pc, raw_instr: skid_instr, error: 1'b0};
        end else if ((state == S_ERR) && err_pend) begin
          f_q <= fetch_data_t'{valid: 1'b1, pc: pc, raw_instr: '0, error: 1'b1};
        end else begin
          f_q.valid <= 1'b0;
        end
      end
    end
  end

endmodule
